// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared definitions for the key event arbiter and the key filter instances
// that feed it: default key count, default re-accept lockout and the arbiter
// FSM state encoding.
// Ports: none (package).
// ---------------------------------------------------------------------------
package key_pkg;

   localparam int          N_KEYS_DEFAULT  = 4;
   localparam int          LOCKOUT_W       = 20;
   // 20 ms at 50 MHz
   localparam logic [19:0] LOCKOUT_DEFAULT = 20'd1_000_000;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } arb_state_t;

endpackage

// File: rtl/key_event_arbiter_if.sv
// ---------------------------------------------------------------------------
// key_event_arbiter_if
// Groups the key pulse inputs, the event valid/ready handshake and the status
// outputs of the key event arbiter.
// Signals:
//   key_pulse  N_KEYS  one-cycle debounced press pulses, one bit per key
//   evt_valid  1       an event is offered on evt_key
//   evt_ready  1       consumer accepts the offered event
//   evt_key    KW      index of the offered key
//   drop       1       one-cycle pulse, a press was lost (key already pending)
//   busy       1       a key is pending or an event is offered
// Modports: master = arbiter side, slave = producer/consumer side.
// ---------------------------------------------------------------------------
interface key_event_arbiter_if
   import key_pkg::*;
#(
   parameter int N_KEYS = N_KEYS_DEFAULT
);
   localparam int KW = $clog2(N_KEYS);

   logic [N_KEYS-1:0] key_pulse;
   logic              evt_valid;
   logic              evt_ready;
   logic [KW-1:0]     evt_key;
   logic              drop;
   logic              busy;

   modport master (
      input  key_pulse, evt_ready,
      output evt_valid, evt_key, drop, busy
   );

   modport slave (
      output key_pulse, evt_ready,
      input  evt_valid, evt_key, drop, busy
   );

endinterface

// File: rtl/key_lockout.sv
// ---------------------------------------------------------------------------
// key_lockout
// Per-key re-accept lockout. Loads LOCKOUT when the key's event is accepted
// and counts down to zero; the key is locked while the count is nonzero.
// LOCKOUT = 0 means the key is never locked.
// Ports:
//   clk     system clock
//   rst     synchronous active-high reset, clears the counter
//   start   key's event accepted this cycle
//   locked  key must not be captured
// ---------------------------------------------------------------------------
module key_lockout
   import key_pkg::*;
#(
   parameter logic [LOCKOUT_W-1:0] LOCKOUT = LOCKOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic locked
);

   logic [LOCKOUT_W-1:0] count;

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every flop samples the values from before the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (start) begin
         count <= LOCKOUT;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign locked = (count != '0);

endmodule

// File: rtl/key_event_arbiter.sv
// ---------------------------------------------------------------------------
// key_event_arbiter
// Collects one-cycle key press pulses into per-key pending bits and offers
// them one at a time on a valid/ready event port, choosing among pending keys
// round robin. An accepted key is locked out for LOCKOUT cycles: presses on a
// locked key are ignored, and a key that is still pending from before its
// acceptance is held back until its lockout expires.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  key_event_arbiter_if.master (key_pulse, evt_valid/ready/key, drop,
//        busy)
// ---------------------------------------------------------------------------
module key_event_arbiter
   import key_pkg::*;
#(
   parameter int                   N_KEYS  = N_KEYS_DEFAULT,
   parameter logic [LOCKOUT_W-1:0] LOCKOUT = LOCKOUT_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   key_event_arbiter_if.master  bus
);

   localparam int KW = $clog2(N_KEYS);

   arb_state_t        state_q, state_d;
   logic [N_KEYS-1:0] pending_q, pending_d;
   logic [N_KEYS-1:0] locked, start, set_mask, clr_mask, eligible;
   logic [KW-1:0]     evt_key_q, evt_key_d;
   logic [KW-1:0]     last_grant_q, last_grant_d;
   logic [KW-1:0]     win_hi, win_lo, winner;
   logic              found_hi, found_lo;
   logic              drop_q, drop_d;

   for (genvar i = 0; i < N_KEYS; i++) begin : g_lock
      key_lockout #(.LOCKOUT(LOCKOUT)) u_lockout (
         .clk    (clk),
         .rst    (rst),
         .start  (start[i]),
         .locked (locked[i])
      );
   end

   // Lockout of the offered key starts on the accepting edge.
   always_comb begin
      start = '0;
      if (state_q == OFFER && bus.evt_ready) start[evt_key_q] = 1'b1;
   end

   // A key pending from before its own acceptance waits out its lockout, so
   // two events for one key are always at least a lockout window apart.
   assign eligible = pending_q & ~locked;

   // Round robin: lowest eligible index above last_grant, else lowest overall
   // (wrap). The loop runs downward so the last hit is the lowest index.
   always_comb begin
      win_hi   = '0;
      win_lo   = '0;
      found_hi = 1'b0;
      found_lo = 1'b0;
      for (int i = N_KEYS - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            win_lo   = KW'(i);
            found_lo = 1'b1;
            if (i > int'(last_grant_q)) begin
               win_hi   = KW'(i);
               found_hi = 1'b1;
            end
         end
      end
      winner = found_hi ? win_hi : win_lo;
   end

   // NOTE: every signal written here gets a default first, so no path through
   // the block can leave a value held and infer a latch.
   always_comb begin
      state_d      = state_q;
      evt_key_d    = evt_key_q;
      last_grant_d = last_grant_q;
      clr_mask     = '0;
      case (state_q)
         IDLE: begin
            if (found_lo) begin
               state_d          = OFFER;
               evt_key_d        = winner;
               last_grant_d     = winner;
               clr_mask[winner] = 1'b1;
            end
         end
         OFFER: begin
            if (bus.evt_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A press on a key being cleared by this grant re-arms it without a drop.
      set_mask  = bus.key_pulse & ~locked;
      pending_d = (pending_q & ~clr_mask) | set_mask;
      drop_d    = |(set_mask & pending_q & ~clr_mask);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         pending_q    <= '0;
         evt_key_q    <= '0;
         last_grant_q <= KW'(N_KEYS - 1);
         drop_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         evt_key_q    <= evt_key_d;
         last_grant_q <= last_grant_d;
         drop_q       <= drop_d;
      end
   end

   assign bus.evt_valid = (state_q == OFFER);
   assign bus.evt_key   = evt_key_q;
   assign bus.drop      = drop_q;
   assign bus.busy      = (state_q == OFFER) || (pending_q != '0);

endmodule

// File: doc/key_event_arbiter.md
KEY_EVENT_ARBITER -- requirements
Module: key_event_arbiter

Interface
REQ-001 Parameter N_KEYS, default 4, number of debounced key pulse inputs; legal range 2..16.
REQ-002 Parameter LOCKOUT, default 20'd1_000_000, re-accept lockout per key in clk cycles (20 ms at 50 MHz); 0 disables lockout.
REQ-003 Local constant KW = $clog2(N_KEYS), width of the key index.
REQ-004 clk  input  1  system clock; all logic on rising edge; one clock domain.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 key_pulse  input  N_KEYS  one-cycle debounced press pulses, one bit per key filter instance.
REQ-007 evt_valid  output  1  an event is offered on evt_key.
REQ-008 evt_ready  input  1  consumer accepts the event when high together with evt_valid.
REQ-009 evt_key  output  KW  index of the offered key.
REQ-010 drop  output  1  one-cycle pulse: a press was lost because that key was already pending.
REQ-011 busy  output  1  high while any key is pending or an event is offered.

Function
REQ-012 Pending capture: pending[i] shall set at the edge after key_pulse[i]=1, if key i is not locked out and pending[i] is not set.
REQ-013 A pulse on a locked-out key shall be ignored silently; pending and drop shall be unaffected.
REQ-014 A pulse on a key whose pending bit is already set, and which is not cleared in that cycle, shall raise drop for exactly one cycle; pending is unchanged.
REQ-015 Simultaneous pulses on several keys in one cycle shall all be captured.
REQ-016 FSM has 2 states: IDLE and OFFER; reset state is IDLE.
REQ-017 IDLE: if pending != 0, select winner by round robin and move to OFFER. At that edge: evt_valid=1, evt_key=winner, pending[winner] cleared.
REQ-018 Round robin: search starts at (last_grant+1) mod N_KEYS, ascending with wrap. last_grant updates on each grant and resets to N_KEYS-1, so key 0 wins first after reset.
REQ-019 OFFER: evt_valid and evt_key stay stable until an edge with evt_ready=1. At that edge: return to IDLE, evt_valid=0, lockout of evt_key starts.
REQ-020 Minimum spacing between accepted events is 2 cycles (one IDLE bubble).
REQ-021 Latency: a pulse at cycle t into an idle, empty block gives evt_valid=1 at cycle t+2.
REQ-022 A pulse on key i in the cycle pending[i] is cleared by a grant shall re-set pending[i]; no drop.
REQ-023 A pulse on the key currently offered in OFFER shall be captured as pending if that key is not locked out.
REQ-024 Lockout: a per-key counter loads LOCKOUT on acceptance and decrements to 0. Key i is locked while its counter is nonzero. With LOCKOUT=0 no key is ever locked.
REQ-025 busy = (state==OFFER) || (pending != 0), registered-equivalent, with no combinational path from key_pulse.
REQ-026 evt_ready while evt_valid=0 shall have no effect.

Reset
REQ-027 rst high at an edge clears pending, all lockout counters, and drop. It also sets state to IDLE, evt_valid=0, evt_key=0, busy=0, last_grant=N_KEYS-1.
REQ-028 rst mid-OFFER shall abort the offer without acceptance; no lockout starts; the event is discarded.
REQ-029 key_pulse sampled while rst is high shall be ignored.

Structure
REQ-030 A shared package/header key_pkg shall hold the FSM state encoding and the default N_KEYS and LOCKOUT values, shared with key filter instantiation.
REQ-031 Sub-module key_lockout, one instance per key, shall hold the down-counter. Ports: clk, rst, start, locked.
REQ-032 Round-robin selection is combinational inside key_event_arbiter; no other sub-modules.

Verification (N_KEYS=4, LOCKOUT=8)
REQ-033 Single press: key_pulse=0001 at t, evt_ready=1 → evt_valid=1 with evt_key=0 at t+2, low at t+3, busy low at t+3.
REQ-034 Simultaneous press: key_pulse=1011 at t, evt_ready=1 → events in order 0, 1, 3, each spaced 2 cycles, drop never set.
REQ-035 Backpressure and drop: key 2 pulsed, evt_ready=0 for 10 cycles, key 2 pulsed again twice → first re-pulse captured pending with no drop; second re-pulse raises drop for 1 cycle; after ready, exactly 2 events with key 2, separated by at least the lockout window.
REQ-036 Lockout: accept key 1, then pulse key 1 at 3 and 7 cycles after acceptance → ignored, no event, no drop; pulse at 9 cycles → event key 1.
REQ-037 Fairness: keys 0 and 3 re-pulsed continuously with LOCKOUT=0 → accepted keys alternate 0, 3, 0, 3.
REQ-038 Reset mid-offer: assert rst during OFFER for key 2 → next edge evt_valid=0, busy=0; a following pulse on key 2 is accepted immediately (no lockout).
